// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-side half of the result path. Takes one load/store command from the
// multicycle control FSM, runs a valid/ready transaction on a word-addressed
// data-memory port, steers byte/halfword lanes and write strobes, and returns
// a registered, sign/zero-extended load word used as the writeback `data`
// operand.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   start              one-cycle command strobe, sampled only in IDLE
//   is_store           1 = store, 0 = load (sampled with start)
//   funct3             RV32I width/sign code (sampled with start)
//   addr               byte address (sampled with start)
//   store_data         rs2 value (sampled with start)
//   busy               high while a command is in REQ or DONE
//   done               one-cycle completion pulse
//   fault              valid with done; misaligned or illegal funct3
//   load_data          extended load result, held until the next good load
//   mem_req/mem_we     request valid / write enable
//   mem_addr           word-aligned address (bits [1:0] = 0)
//   mem_wdata          lane-replicated store data
//   mem_wstrb          byte write enables, 0000 on reads
//   mem_ready          memory accepts; read data valid in the same cycle
//   mem_rdata          read word
//
// Timing: the done pulse is registered one cycle after the FSM enters DONE,
// so a zero-wait access reports done after edge N+2 for a start sampled at
// edge N, and a faulting command reports done after edge N+1.
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic              fault_pend_q;
  logic              done_q, fault_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;
  logic [31:0]       load_data_q;

  // ---------------------------------------------------------------------------
  // Command decode on the raw inputs (only consumed when start is taken).
  // ---------------------------------------------------------------------------
  logic        legal_f3, misaligned, cmd_ok;
  logic [31:0] wdata_steer;
  logic [3:0]  wstrb_steer;

  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path through the case statements can leave it unassigned (latch).
    legal_f3    = 1'b0;
    misaligned  = 1'b0;
    wdata_steer = store_data;
    wstrb_steer = 4'b1111;

    if (is_store) begin
      legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b101);
    end

    // funct3[1:0] encodes the access width for every legal code.
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    case (funct3[1:0])
      2'b00: begin
        wdata_steer = {4{store_data[7:0]}};
        wstrb_steer = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_steer = {2{store_data[15:0]}};
        wstrb_steer = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        wdata_steer = store_data;
        wstrb_steer = 4'b1111;
      end
    endcase
  end

  assign cmd_ok = legal_f3 && !misaligned;

  // ---------------------------------------------------------------------------
  // Load extraction from the live read word, using the latched command.
  // ---------------------------------------------------------------------------
  logic [31:0] byte_shift, half_shift, load_ext;

  assign byte_shift = mem_rdata >> {addr_lo_q, 3'b000};
  assign half_shift = mem_rdata >> {addr_lo_q[1], 4'b0000};

  always_comb begin
    load_ext = mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b001:  load_ext = {{16{half_shift[15]}}, half_shift[15:0]};
      3'b100:  load_ext = {24'h0, byte_shift[7:0]};
      3'b101:  load_ext = {16'h0, half_shift[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = cmd_ok ? ST_REQ : ST_DONE;
      ST_REQ:  if (mem_ready) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: all state is written with non-blocking assignments so every register
  // samples pre-edge values; the reset branch is asynchronous and clears every
  // output register, so a reset mid-transaction drops mem_req at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      fault_pend_q <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      load_data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      fault_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            is_store_q   <= is_store;
            funct3_q     <= funct3;
            addr_lo_q    <= addr[1:0];
            fault_pend_q <= !cmd_ok;
            // A faulting command never touches the memory-side registers.
            if (cmd_ok) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              mem_wdata_q <= wdata_steer;
              mem_wstrb_q <= is_store ? wstrb_steer : 4'b0000;
            end
          end
        end

        ST_REQ: begin
          // Request registers are untouched while waiting, so the memory sees
          // a stable request across any number of wait states.
          if (mem_ready) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            if (!is_store_q) load_data_q <= load_ext;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b1;
          fault_q <= fault_pend_q;
        end

        default: ;
      endcase
    end
  end

  assign busy      = (state_q == ST_REQ) || (state_q == ST_DONE);
  assign done      = done_q;
  assign fault     = fault_q;
  assign load_data = load_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed, table-driven bench for load_store_unit. Each table record holds a
// command, the memory response (read word and wait states) and hand-computed
// expectations. Hand-written sequences cover reset behaviour and a start
// pulse arriving during an in-flight request.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .store_data(store_data),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .load_data (load_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          waits;
    logic        flt;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] load;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  cyc;
    int  seen_req;
    bit  stable_ok;
    is_store   = v.st;
    funct3     = v.f3;
    addr       = v.addr;
    store_data = v.sd;
    mem_rdata  = v.rdata;
    start      = 1'b1;
    step();                       // start sampled at edge N
    start      = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    cyc        = 0;
    seen_req   = 0;
    stable_ok  = 1'b1;
    while (!done && cyc < 50) begin
      if (mem_req) begin
        if (mem_addr !== v.maddr || mem_wstrb !== v.wstrb || mem_we !== v.st) stable_ok = 1'b0;
        if (v.st && mem_wdata !== v.wdata) stable_ok = 1'b0;
        mem_ready = (seen_req >= v.waits);
        seen_req++;
      end else begin
        mem_ready = 1'b0;
      end
      step();
      cyc++;
    end
    mem_ready = 1'b0;
    check($sformatf("v%0d_latency", idx), cyc, v.lat);
    check($sformatf("v%0d_fault", idx), {31'h0, fault}, {31'h0, v.flt});
    check($sformatf("v%0d_req_cycles", idx), seen_req, v.flt ? 0 : v.waits + 1);
    check($sformatf("v%0d_req_stable", idx), {31'h0, stable_ok}, 32'h1);
    check($sformatf("v%0d_load_data", idx), load_data, v.load);
    step();
    check($sformatf("v%0d_done_one_cycle", idx), {30'h0, done, busy}, 32'h0);
  endtask

  initial begin
    int done_cnt;
    bit ok;

    //       st    f3      addr          sd            rdata        w  flt maddr         wdata         wstrb    load          lat
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'hDEAD_BEEF, 2};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'hFFFF_FF80, 2};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_0080, 2};
    vecs[3]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_0000, 0, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_80FF, 2};
    vecs[4]  = '{1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 32'h5555_5555, 3, 1'b0, 32'h0000_0200, 32'hABAB_ABAB, 4'b0010, 32'h0000_80FF, 5};
    vecs[5]  = '{1'b1, 3'b001, 32'h0000_0203, 32'h0000_CAFE, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0000_80FF, 1};
    vecs[6]  = '{1'b0, 3'b011, 32'h0000_0300, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0000_80FF, 1};
    vecs[7]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h0000_CAFE, 32'h0,        0, 1'b0, 32'h0000_0200, 32'hCAFE_CAFE, 4'b1100, 32'h0000_80FF, 2};
    vecs[8]  = '{1'b0, 3'b001, 32'h0000_0106, 32'h0,        32'h9ABC_1234, 1, 1'b0, 32'h0000_0104, 32'h0,        4'b0000, 32'hFFFF_9ABC, 3};
    vecs[9]  = '{1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_007F, 0, 1'b0, 32'h0000_0100, 32'h0,        4'b0000, 32'h0000_007F, 2};
    vecs[10] = '{1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'hFFFF_FFFF, 0, 1'b0, 32'h0000_0010, 32'h1122_3344, 4'b1111, 32'h0000_007F, 2};
    vecs[11] = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0000_007F, 1};
    vecs[12] = '{1'b1, 3'b100, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0000_007F, 1};
    vecs[13] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0000_007F, 1};

    // ---- Reset with random inputs: every output must read zero. ----
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start      = 1'($urandom);
      is_store   = 1'($urandom);
      funct3     = 3'($urandom);
      addr       = $urandom;
      store_data = $urandom;
      mem_ready  = 1'($urandom);
      mem_rdata  = $urandom;
      step();
    end
    check("reset_ctrl", {29'h0, busy, done, fault}, 32'h0);
    check("reset_mem_ctl", {29'h0, mem_req, mem_we, 1'b0}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    check("reset_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("reset_load_data", load_data, 32'h0);

    start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    step();
    reset = 1'b0;
    step();

    // ---- Reset asserted while mem_req is high. ----
    funct3 = 3'b010; addr = 32'h0000_0040; start = 1'b1;
    step();
    start = 1'b0;
    check("midrst_req_before", {31'h0, mem_req}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("midrst_req_dropped", {30'h0, mem_req, busy}, 32'h0);
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      step();
    end
    mem_ready = 1'b0;
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle", {30'h0, busy, mem_req}, 32'h0);

    // ---- Table-driven commands, issued back-to-back after each done. ----
    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // ---- start pulsed during REQ is ignored. ----
    funct3 = 3'b010; addr = 32'h0000_0180; mem_rdata = 32'h55AA_55AA;
    is_store = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    ok = 1'b1;
    done_cnt = 0;
    // First REQ cycle: pulse a store command that must be dropped.
    is_store = 1'b1; funct3 = 3'b010; addr = 32'h0000_0500;
    store_data = 32'hFFFF_FFFF; start = 1'b1;
    step();
    start = 1'b0; is_store = 1'b0; addr = 32'h0;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0180 || mem_we !== 1'b0) ok = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) done_cnt++;
      if (mem_req) ok = 1'b0;
      step();
    end
    check("ignore_req_unchanged", {31'h0, ok}, 32'h1);
    check("ignore_single_done", done_cnt, 1);
    check("ignore_load_data", load_data, 32'h55AA_55AA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
